// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard-detection inputs and the stall/flush/status outputs
//   exchanged between the pipeline datapath and the hazard controller.
//   master : datapath side (drives hazard inputs, consumes stall/flush)
//   slave  : hazard controller side
// Signals
//   ID_SrcReg1/2   source registers of the instruction in ID
//   ID_EX_MemRead  instruction in EX is a load
//   ID_EX_reg_rd   destination register of the instruction in EX
//   ID_br_taken    branch in ID resolved taken
//   ID_HLT/WB_HLT  HLT decoded in ID / HLT reached WB
//   mem_busy       data memory not ready
//   *_stall/*_flush pipeline register controls
//   hlt_done, mem_timeout, stall_cycles  status outputs
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_SrcReg1;
    logic [REG_W-1:0] ID_SrcReg2;
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_reg_rd;
    logic             ID_br_taken;
    logic             ID_HLT;
    logic             WB_HLT;
    logic             mem_busy;

    logic             PC_stall;
    logic             IF_ID_stall;
    logic             IF_ID_flush;
    logic             ID_EX_stall;
    logic             ID_EX_flush;
    logic             EX_MEM_stall;
    logic             MEM_WB_flush;
    logic             hlt_done;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ID_SrcReg1, ID_SrcReg2, ID_EX_MemRead, ID_EX_reg_rd,
               ID_br_taken, ID_HLT, WB_HLT, mem_busy,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, hlt_done, mem_timeout, stall_cycles
    );

    modport slave (
        input  ID_SrcReg1, ID_SrcReg2, ID_EX_MemRead, ID_EX_reg_rd,
               ID_br_taken, ID_HLT, WB_HLT, mem_busy,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, hlt_done, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. Handles load-use
//   hazards, taken-branch squash, multi-cycle data-memory waits and HLT
//   drain-to-halt. Keeps a saturating stall-cycle counter and a sticky
//   memory-timeout flag.
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   hz   slave side of pipeline_hazard_ctrl_if (hazard inputs, stall/flush
//        controls, hlt_done, mem_timeout, stall_cycles)
// The interface instance must use the same REG_W/CNT_W as this module.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              hlt_done_q;
    logic              mem_timeout_q;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, mem_wb_flush;
    logic lu;

    // Load-use: the load in EX writes a register the ID instruction reads.
    // R0 is hard-wired zero, so a load into it never creates a dependency.
    assign lu = hz.ID_EX_MemRead
              && (hz.ID_EX_reg_rd != '0)
              && ((hz.ID_EX_reg_rd == REG_W'(hz.ID_SrcReg1))
               || (hz.ID_EX_reg_rd == REG_W'(hz.ID_SrcReg2)));

    // Next state and stall/flush decode.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        state_next   = state;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;

        if (!rst) begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    if (hz.mem_busy) begin
                        // Freeze everything up to MEM; WB gets bubbles. A pending
                        // branch stays in ID and is honoured once memory is ready.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                        state_next   = MEM_WAIT;
                    end else begin
                        state_next = RUN;
                        if (lu) begin
                            // One bubble; the load then leaves EX and lu drops.
                            pc_stall    = 1'b1;
                            if_id_stall = 1'b1;
                            id_ex_flush = 1'b1;
                        end else begin
                            if_id_flush = hz.ID_br_taken;
                            if (hz.ID_HLT) state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    pc_stall = 1'b1;
                    if (hz.mem_busy) begin
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                    end else if (lu) begin
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        // Keep feeding NOPs so nothing fetched after HLT executes.
                        if_id_flush = 1'b1;
                    end
                    if (hz.WB_HLT) state_next = HALTED;
                end
                HALTED: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            hlt_done_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_cnt     <= '0;
            wait_cnt      <= '0;
        end else begin
            state      <= state_next;
            hlt_done_q <= (state_next == HALTED);

            if (hz.mem_busy) begin
                if (wait_cnt == WAIT_LAST) mem_timeout_q <= 1'b1;
                else                       wait_cnt      <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (pc_stall && (state != HALTED) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.PC_stall     = pc_stall;
    assign hz.IF_ID_stall  = if_id_stall;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_stall  = id_ex_stall;
    assign hz.ID_EX_flush  = id_ex_flush;
    assign hz.EX_MEM_stall = ex_mem_stall;
    assign hz.MEM_WB_flush = mem_wb_flush;
    assign hz.hlt_done     = hlt_done_q;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_cnt;

endmodule
